// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block loader.
// Holds FSM encoding, key-size codes and byte lengths.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_PT,
        S_START,
        S_WAIT
    } state_t;

    localparam logic [1:0] N_128 = 2'b00;
    localparam logic [1:0] N_192 = 2'b01;
    localparam logic [1:0] N_256 = 2'b10;

    localparam logic [5:0] KEY_LEN_128 = 6'd16;
    localparam logic [5:0] KEY_LEN_192 = 6'd24;
    localparam logic [5:0] KEY_LEN_256 = 6'd32;

    localparam logic [5:0] PT_LEN = 6'd16;

    // Code 11 falls back to a 128-bit key.
    function automatic logic [5:0] key_len(input logic [1:0] n);
        case (n)
            N_192:   key_len = KEY_LEN_192;
            N_256:   key_len = KEY_LEN_256;
            default: key_len = KEY_LEN_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// Byte-addressed register: byte idx lands in the MSB-first slot.
// Clear and write may coincide; the write wins for its slot.
module aes_byte_shifter #(
    parameter int W  = 128,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [IW-1:0] i_idx,
    input  logic [7:0]    i_din,
    output logic [W-1:0]  o_q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = i_clr ? '0 : r_q;
        for (int b = 0; b < W / 8; b++) begin
            if (i_we && i_idx == IW'(b)) begin
                w_next[W-1-8*b -: 8] = i_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/aes_block_loader.sv
// Serial byte loader assembling key and plaintext for an AES core.
// Issues a start pulse, then waits for core_done or a timeout.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   N,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic         core_done,
    output logic [127:0] In,
    output logic [255:0] Key,
    output logic         start,
    output logic         busy,
    output logic [7:0]   blk_cnt,
    output logic         err
);

    localparam int WW = $clog2(WAIT_LIMIT + 1);

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_cnt;
    logic [1:0]      r_n;
    logic [7:0]      r_blk;
    logic            r_err;
    logic [WW-1:0]   r_wait;

    logic            w_xfer;
    logic            w_key_last;
    logic            w_pt_last;
    logic            w_timeout;
    logic            w_clr;
    logic            w_key_we;
    logic            w_in_we;

    assign w_xfer     = byte_valid & byte_ready;
    assign w_key_last = (r_cnt == key_len(r_n) - 6'd1);
    assign w_pt_last  = (r_cnt == PT_LEN - 6'd1);
    assign w_timeout  = ~core_done & (r_wait == WW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_next = S_KEY;
            S_KEY:   if (w_xfer && w_key_last) w_next = S_PT;
            S_PT:    if (w_xfer && w_pt_last) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (core_done || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b1;
        start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                byte_ready = 1'b1;
                busy       = 1'b0;
            end
            S_KEY:   byte_ready = 1'b1;
            S_PT:    byte_ready = 1'b1;
            S_START: start = 1'b1;
            default: ;
        endcase
    end

    assign w_clr    = w_xfer & (r_state == S_IDLE);
    assign w_key_we = w_xfer & (r_state == S_IDLE || r_state == S_KEY);
    assign w_in_we  = w_xfer & (r_state == S_PT);

    // r_cnt is always zero in IDLE, so the first key byte lands at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_n    <= N_128;
            r_blk  <= '0;
            r_err  <= 1'b0;
            r_wait <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_n   <= N;
                        r_cnt <= 6'd1;
                        r_err <= 1'b0;
                    end
                end
                S_KEY: begin
                    if (w_xfer) r_cnt <= w_key_last ? '0 : r_cnt + 6'd1;
                end
                S_PT: begin
                    if (w_xfer) r_cnt <= w_pt_last ? '0 : r_cnt + 6'd1;
                end
                S_START: begin
                    r_blk  <= r_blk + 8'd1;
                    r_wait <= '0;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_wait <= '0;
                    end else if (w_timeout) begin
                        r_wait <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    aes_byte_shifter #(.W(256), .IW(5)) u_key (
        .clk   (clk),
        .i_rst (rst),
        .i_clr (w_clr),
        .i_we  (w_key_we),
        .i_idx (r_cnt[4:0]),
        .i_din (byte_in),
        .o_q   (Key)
    );

    aes_byte_shifter #(.W(128), .IW(4)) u_in (
        .clk   (clk),
        .i_rst (rst),
        .i_clr (w_clr),
        .i_we  (w_in_we),
        .i_idx (r_cnt[3:0]),
        .i_din (byte_in),
        .o_q   (In)
    );

    assign blk_cnt = r_blk;
    assign err     = r_err;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader.
// Table-driven loads plus hand sequences for reset, timeout and wrap.
module tb_aes_block_loader;

    localparam int WL = 4;

    localparam logic [255:0] K128 =
        {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 =
        {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT =
        128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   N;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         core_done;
    logic [127:0] In;
    logic [255:0] Key;
    logic         start;
    logic         busy;
    logic [7:0]   blk_cnt;
    logic         err;

    aes_block_loader #(.WAIT_LIMIT(WL)) dut (
        .clk        (clk),
        .rst        (rst),
        .N          (N),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .core_done  (core_done),
        .In         (In),
        .Key        (Key),
        .start      (start),
        .busy       (busy),
        .blk_cnt    (blk_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] in;
        logic [255:0] key;
    } exp_t;

    typedef struct {
        logic [1:0]   n;
        logic [1:0]   n_mid;
        bit           gap;
        logic [255:0] key;
        logic [127:0] in;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         last_x   = -10;
    int         n_xfer   = 0;
    logic       prev_start = 1'b0;
    logic [7:0] exp_blk  = 8'd0;
    exp_t       sb[$];
    vec_t       vt[5];

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (byte_valid && byte_ready && !rst) begin
            n_xfer++;
            last_x = cyc;
        end
        if (start) begin
            chk("start_one_cycle", {255'd0, prev_start}, 256'd0);
            chk("start_latency", cyc, last_x + 1);
            if (sb.size() == 0) begin
                fail_now("start_unexpected");
            end else begin
                e = sb.pop_front();
                chk("sb_In", {128'd0, In}, {128'd0, e.in});
                chk("sb_Key", Key, e.key);
            end
        end
        prev_start = start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] n,
                        input bit gap, input bit last, input exp_t e);
        bit ok;
        ok = 1'b0;
        if (gap) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_in    = b;
        N          = n;
        byte_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (byte_ready) begin
                ok = 1'b1;
                if (last) sb.push_back(e);
                tick();
                break;
            end
            tick();
        end
        byte_valid = 1'b0;
        if (!ok) fail_now("xfer_timeout");
    endtask

    task automatic load(input logic [1:0] n, input logic [1:0] n_mid,
                        input bit gap, input logic [255:0] k,
                        input logic [127:0] p);
        exp_t e;
        int   kl;
        int   x0;
        kl    = (n == 2'b01) ? 24 : (n == 2'b10) ? 32 : 16;
        e.in  = p;
        e.key = k;
        x0    = n_xfer;
        for (int i = 0; i < kl; i++)
            send(8'(i), (i == 0) ? n : n_mid, gap, 1'b0, e);
        for (int i = 0; i < 16; i++)
            send(8'(i * 17), n_mid, gap, i == 15, e);
        chk("xfer_count", n_xfer - x0, kl + 16);
        exp_blk = exp_blk + 8'd1;
    endtask

    task automatic wait_start();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (start) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) fail_now("start_timeout");
    endtask

    task automatic finish_block();
        wait_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_ready", {255'd0, byte_ready}, 256'd0);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_busy", {255'd0, busy}, 256'd0);
        chk("done_ready", {255'd0, byte_ready}, 256'd1);
        chk("blk_cnt", {248'd0, blk_cnt}, {248'd0, exp_blk});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        vt[0] = '{2'b00, 2'b00, 1'b0, K128, PT};
        vt[1] = '{2'b10, 2'b10, 1'b0, K256, PT};
        vt[2] = '{2'b01, 2'b10, 1'b1, K192, PT};
        vt[3] = '{2'b11, 2'b10, 1'b0, K128, PT};
        vt[4] = '{2'b00, 2'b11, 1'b1, K128, PT};

        rst        = 1'b1;
        N          = 2'b00;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        core_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {255'd0, byte_ready}, 256'd1);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_In", {128'd0, In}, 256'd0);
        chk("rst_Key", Key, 256'd0);
        chk("rst_blk", {248'd0, blk_cnt}, 256'd0);
        chk("rst_err", {254'd0, err, start}, 256'd0);

        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("idle_done_busy", {255'd0, busy}, 256'd0);

        foreach (vt[i]) begin
            load(vt[i].n, vt[i].n_mid, vt[i].gap, vt[i].key, vt[i].in);
            finish_block();
        end

        begin
            exp_t e;
            e.in  = PT;
            e.key = K192;
            for (int i = 0; i < 20; i++)
                send(8'(i), 2'b01, 1'b0, 1'b0, e);
        end
        byte_valid = 1'b1;
        core_done  = 1'b1;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        byte_valid = 1'b0;
        core_done  = 1'b0;
        exp_blk    = 8'd0;
        chk("mid_rst_In", {128'd0, In}, 256'd0);
        chk("mid_rst_Key", Key, 256'd0);
        chk("mid_rst_blk", {248'd0, blk_cnt}, 256'd0);
        chk("mid_rst_busy", {254'd0, busy, err}, 256'd0);
        chk("mid_rst_ready", {255'd0, byte_ready}, 256'd1);
        repeat (5) tick();
        load(2'b00, 2'b00, 1'b0, K128, PT);
        finish_block();

        load(2'b00, 2'b00, 1'b0, K128, PT);
        wait_start();
        repeat (WL) tick();
        chk("to_busy_before", {255'd0, busy}, 256'd1);
        chk("to_err_before", {255'd0, err}, 256'd0);
        tick();
        chk("to_err", {255'd0, err}, 256'd1);
        chk("to_busy", {255'd0, busy}, 256'd0);
        repeat (2) tick();
        chk("to_err_sticky", {255'd0, err}, 256'd1);
        load(2'b10, 2'b10, 1'b0, K256, PT);
        chk("to_err_cleared", {255'd0, err}, 256'd0);
        finish_block();

        load(2'b00, 2'b00, 1'b0, K128, PT);
        wait_start();
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_blk = 8'd0;
        chk("wait_rst_busy", {255'd0, busy}, 256'd0);
        repeat (5) tick();
        chk("wait_rst_blk", {248'd0, blk_cnt}, 256'd0);

        for (int b = 0; b < 256; b++) begin
            load(2'b00, 2'b00, 1'b0, K128, PT);
            finish_block();
        end
        chk("wrap_blk", {248'd0, blk_cnt}, 256'd0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
